// File: rtl/window_pkg.sv
// Shared types and fixed-point helpers for the window_stream block.
package window_pkg;

  typedef enum logic {
    WIN_BYPASS = 1'b0,
    WIN_TABLE  = 1'b1
  } window_mode_e;

  function automatic int unsigned unity_coef(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

  // Clamp a signed value into the two's-complement range of 'width' bits.
  function automatic int sat_signed(input int value, input int unsigned width);
    int hi;
    int lo;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/window_coef_ram.sv
// Per-index window coefficient table: one write port, one combinational read port.
module window_coef_ram #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned COEF_W    = 8,
  parameter int unsigned COEF_FRAC = 7,
  parameter int unsigned IDX_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [COEF_W-1:0] rd_data
);
  import window_pkg::*;

  localparam logic [COEF_W-1:0] UNITY = COEF_W'(unity_coef(COEF_FRAC));

  logic [COEF_W-1:0] mem [FRAME_LEN];

  // Reads see the pre-write contents when addresses collide.
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FRAME_LEN); i++) begin
        mem[i] <= UNITY;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/window_stream.sv
// Streaming window multiplier: per-index coefficient, round half up, saturate,
// two-stage pipeline with valid/ready on both sides and a frame-last marker.
module window_stream #(
  parameter  int unsigned DATA_W    = 8,
  parameter  int unsigned COEF_W    = 8,
  parameter  int unsigned COEF_FRAC = 7,
  parameter  int unsigned FRAME_LEN = 8,
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     frame_clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     coef_wr_en,
  input  logic [IDX_W-1:0]         coef_wr_addr,
  input  logic [COEF_W-1:0]        coef_wr_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last
);
  import window_pkg::*;

  localparam int unsigned P_W      = DATA_W + COEF_W + 1;
  localparam int unsigned LAST_IDX = FRAME_LEN - 1;
  localparam logic [COEF_W-1:0]     UNITY = COEF_W'(unity_coef(COEF_FRAC));
  localparam logic signed [P_W-1:0] ROUND = P_W'(unity_coef(COEF_FRAC - 1));

  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_use_c;
  logic [IDX_W-1:0]  idx_next_c;
  window_mode_e      mode_q;
  window_mode_e      mode_use_c;
  logic              stall_c;
  logic              accept_c;
  logic              frame_start_c;
  logic [COEF_W-1:0] tbl_rd_c;
  logic [COEF_W-1:0] coef_c;

  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_data;
  logic [COEF_W-1:0]        s1_coef;
  logic                     s1_last;

  logic signed [P_W-1:0]    a_c;
  logic signed [P_W-1:0]    b_c;
  logic signed [P_W-1:0]    p_c;
  logic signed [P_W-1:0]    r_c;
  logic signed [DATA_W-1:0] sat_c;

  assign stall_c  = out_valid & ~out_ready;
  assign in_ready = ~stall_c;
  assign accept_c = in_valid & in_ready;

  window_coef_ram #(
    .FRAME_LEN (FRAME_LEN),
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC),
    .IDX_W     (IDX_W)
  ) u_coef_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (coef_wr_en),
    .wr_addr (coef_wr_addr),
    .wr_data (coef_wr_data),
    .rd_addr (idx_use_c),
    .rd_data (tbl_rd_c)
  );

  // Frame index, mode selection and coefficient lookup for the incoming sample.
  always_comb begin
    idx_use_c     = frame_clr ? '0 : idx;
    frame_start_c = (idx_use_c == '0);
    mode_use_c    = mode_q;
    idx_next_c    = idx_use_c;
    if (accept_c && frame_start_c) begin
      mode_use_c = window_mode_e'(mode);
    end
    coef_c = (mode_use_c == WIN_TABLE) ? tbl_rd_c : UNITY;
    if (accept_c) begin
      if (idx_use_c == IDX_W'(LAST_IDX)) begin
        idx_next_c = '0;
      end else begin
        idx_next_c = idx_use_c + IDX_W'(1);
      end
    end
  end

  // Signed product against a zero-extended coefficient, then round half up and clamp.
  always_comb begin
    a_c   = P_W'(s1_data);
    b_c   = P_W'({1'b0, s1_coef});
    p_c   = a_c * b_c;
    r_c   = (p_c + ROUND) >>> COEF_FRAC;
    sat_c = DATA_W'(sat_signed(int'(r_c), DATA_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      mode_q <= WIN_BYPASS;
    end else begin
      idx <= idx_next_c;
      if (accept_c && frame_start_c) begin
        mode_q <= window_mode_e'(mode);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_coef  <= '0;
      s1_last  <= 1'b0;
    end else if (!stall_c) begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_data <= in_data;
        s1_coef <= coef_c;
        s1_last <= (idx_use_c == IDX_W'(LAST_IDX));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (!stall_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= sat_c;
        out_last <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_window_stream.sv
// Scoreboard bench for window_stream: directed scenarios plus a randomized phase,
// checked against a real-arithmetic reference model of the windowing rules.
module tb_window_stream;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mode = 1'b0;
  logic              frame_clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_data = '0;
  logic              coef_wr_en = 1'b0;
  logic [2:0]        coef_wr_addr = '0;
  logic [7:0]        coef_wr_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [7:0] out_data;
  logic              out_last;

  always #5 clk = ~clk;

  window_stream dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .frame_clr    (frame_clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last)
  );

  typedef struct {
    int data;
    bit last;
    int cyc;
    bit lat;
  } exp_t;

  exp_t sbq[$];
  exp_t e_new;
  exp_t e_got;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   m_idx = 0;
  bit   m_mode = 1'b0;
  int   m_tbl[8];
  bit   lat_chk = 1'b0;
  bit   prev_hold = 1'b0;
  int   prev_data = 0;
  int   prev_last = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Window sample x by coefficient c (c/128), round half up, clamp to 8-bit signed.
  function automatic int ref_out(input int x, input int c);
    real v;
    int  r;
    v = (x * c) / 128.0;
    r = $rtoi($floor(v + 0.5));
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  // Reference model and output monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sbq.delete();
      m_idx = 0;
      m_mode = 1'b0;
      for (int i = 0; i < 8; i++) m_tbl[i] = 128;
      prev_hold = 1'b0;
    end else begin
      chk("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
      if (prev_hold) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), prev_data);
        chk("hold_last", int'(out_last), prev_last);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got data %0d with empty scoreboard (cycle %0d)", out_data, cyc);
        end else begin
          e_got = sbq.pop_front();
          chk("out_data", int'(out_data), e_got.data);
          chk("out_last", int'(out_last), int'(e_got.last));
          if (e_got.lat) chk("latency", cyc - e_got.cyc, 2);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = int'(out_data);
      prev_last = int'(out_last);
      if (frame_clr) m_idx = 0;
      if (in_valid && in_ready) begin
        if (m_idx == 0) m_mode = mode;
        e_new.data = ref_out(int'(in_data), m_mode ? m_tbl[m_idx] : 128);
        e_new.last = (m_idx == 7);
        e_new.cyc  = cyc;
        e_new.lat  = lat_chk;
        sbq.push_back(e_new);
        m_idx = (m_idx + 1) % 8;
      end
      if (coef_wr_en) m_tbl[coef_wr_addr] = int'(coef_wr_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input bit clr = 1'b0);
    int n;
    in_valid  = 1'b1;
    in_data   = 8'(x);
    frame_clr = clr;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        break;
      end
    end
    step();
    frame_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic wr(input int a, input int d);
    in_valid     = 1'b0;
    coef_wr_en   = 1'b1;
    coef_wr_addr = 3'(a);
    coef_wr_data = 8'(d);
    step();
    coef_wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) step();
    rst = 1'b0;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_out_last", int'(out_last), 0);
    chk("reset_in_ready", int'(in_ready), 1);

    // Bypass stream 1..8
    lat_chk = 1'b1;
    for (int i = 1; i <= 8; i++) send(i);
    idle(4);

    // Half-scale coefficients
    for (int a = 0; a < 8; a++) wr(a, 64);
    mode = 1'b1;
    send(100); send(-3); send(3); send(-128);
    for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 255)) - 128);
    idle(4);

    // Saturation on coefficient 255 at frame start
    wr(0, 255);
    send(127);
    for (int i = 0; i < 7; i++) send(int'($urandom_range(0, 255)) - 128);
    send(-128);
    for (int i = 0; i < 7; i++) send(int'($urandom_range(0, 255)) - 128);
    idle(4);

    // Downstream stall mid-stream
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(int'($urandom_range(0, 255)) - 128);
        idle(2);
      end
      begin
        repeat (5) step();
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
      end
    join
    idle(6);

    // Mode change mid-frame, then frame_clr on an accept at idx 5
    lat_chk = 1'b1;
    mode = 1'b0;
    send(10); send(20); send(30);
    mode = 1'b1;
    send(40); send(50);
    send(50, 1'b1);
    for (int i = 0; i < 7; i++) send(int'($urandom_range(0, 255)) - 128);
    idle(4);

    // Reset with samples in flight
    lat_chk = 1'b0;
    for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 255)) - 128);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_last", int'(out_last), 0);
    chk("midrst_out_data", int'(out_data), 0);
    step(); step();
    rst = 1'b0;
    mode = 1'b1;
    for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 255)) - 128);
    idle(4);

    // Randomized traffic with writes, clears, mode flips and backpressure
    for (int i = 0; i < 300; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_data      = 8'($urandom);
      out_ready    = ($urandom_range(0, 3) != 0);
      frame_clr    = ($urandom_range(0, 15) == 0);
      coef_wr_en   = ($urandom_range(0, 5) == 0);
      coef_wr_addr = 3'($urandom);
      coef_wr_data = 8'($urandom);
      if ($urandom_range(0, 31) == 0) mode = ~mode;
      step();
    end
    frame_clr  = 1'b0;
    coef_wr_en = 1'b0;
    out_ready  = 1'b1;
    idle(8);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_stream.md
Name: window_stream

Overview:
- Streaming, clocked successor to the combinational window multiplier.
- Applies a per-index window coefficient to a continuous stream of signed samples, one sample per handshake.
- Frame length, sample/coefficient widths and fixed-point scaling are parameters; coefficients live in a runtime-loadable table.
- Sits between the sample source and the transform stage, with valid/ready on both sides and a frame-last marker on the output.

Parameters:
- DATA_W, 8, signed sample width (in and out).
- COEF_W, 8, unsigned coefficient width.
- COEF_FRAC, 7, fractional bits of the coefficient (unity = 1<<COEF_FRAC = 128).
- FRAME_LEN, 8, samples per frame (>=2); index width IDX_W = $clog2(FRAME_LEN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = bypass (unity coefficient), 1 = table coefficients.
- frame_clr  in  1  synchronous frame index restart.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  DATA_W  signed input sample.
- coef_wr_en  in  1  coefficient table write strobe.
- coef_wr_addr  in  IDX_W  coefficient table write index.
- coef_wr_data  in  COEF_W  coefficient value.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  DATA_W  windowed, signed, saturated sample.
- out_last  out  1  high on the output of frame index FRAME_LEN-1.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_last=0; pipeline valids cleared.
  - Frame index=0, latched frame mode=0.
  - All table entries = unity.
  - in_ready=1 in the first cycle after release.
- Handshake and stall:
  - Accept on in_valid & in_ready; emit on out_valid & out_ready.
  - out_data/out_last are held stable while out_valid=1 and out_ready=0.
  - stall = stage2 valid & !out_ready; in_ready = !stall.
  - With stall low, both stages advance every cycle, so throughput is 1 sample/clk.
- Pipeline, latency 2 cycles from accept to out_valid:
  - S1 registers the sample, the coefficient (table[idx], or unity when the latched mode is 0), and last = (idx==FRAME_LEN-1).
  - S2 computes p = sample * {1'b0,coef} as a signed product of DATA_W+COEF_W+1 bits.
  - r = (p + (1<<(COEF_FRAC-1))) >>> COEF_FRAC, i.e. round half up, arithmetic shift.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and register into out_data.
- Frame index:
  - Increments on every accept and wraps FRAME_LEN-1 -> 0.
  - Mode is latched only on an accept at idx 0; a mode change mid-frame takes effect at the next frame.
- frame_clr:
  - Forces idx to 0 and does not touch in-flight data.
  - If it coincides with an accept, that sample uses idx 0, mode is latched then, and idx becomes 1.
- Table write:
  - Takes effect from the next cycle.
  - A write to the address read in the same cycle returns the old value.
  - Writes are permitted at any time, including during a stall.
- Stall does not corrupt S1: S1 holds while S2 is stalled.
- Reset mid-frame discards all in-flight samples; nothing partial is emitted.

Decomposition:
- Package window_pkg:
  - window_mode_e enum {WIN_BYPASS, WIN_TABLE}.
  - Function unity_coef(COEF_FRAC).
  - Function sat_signed(value, width).
- Sub-module window_coef_ram: FRAME_LEN x COEF_W, async-reset to unity, one write port and one combinational read port indexed by the frame index.
- Top module: handshake, index counter, mode latch, 2-stage multiply/round/saturate.

Test Plan:
1. Reset, mode=0, stream 1..8 with out_ready=1 -> out_data 1..8, first out_valid 2 cycles after the first accept, out_last only with 8, in_ready constantly 1.
2. Load all coef=64 (0.5), mode=1, inputs 100,-3,3,-128 -> outputs 50,-1,2,-64.
3. Load coef[0]=255, inputs 127 then -128 at idx 0 of successive frames -> saturate to 127 and -128.
4. Stream 16 samples with out_ready low for 5 cycles mid-stream -> in_ready falls while stalled, all 16 outputs arrive in order with no loss or duplication, out_data held during the stall.
5. frame_clr coincident with an accept at idx 5 -> that sample uses coef[0], out_last appears 7 outputs later; mode toggled at idx 3 -> applied from the next idx-0 sample only.
6. Assert rst at idx 4 with 2 samples in flight -> out_valid=0 immediately, no stale output after release, next sample uses idx 0 with a unity coefficient.
